// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
package matrix_pkg;

  localparam int unsigned DefN = 4;
  localparam int unsigned DefW = 16;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  // Bit offset of element [r][c] in a row-major packed N x N matrix of W-bit elements.
  function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                           input int unsigned n, input int unsigned w);
    return (r * n + c) * w;
  endfunction

  // Clamp a signed value to the signed w-bit range; accumulators must fit in 64 bits.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed W x W multiply-accumulate; exposes the accumulator value including the current product.
module mac_unit #(
  parameter int unsigned W    = 16,
  parameter int unsigned AccW = 34
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   acc_en_i,
  input  logic [W-1:0]           a_i,
  input  logic [W-1:0]           b_i,
  output logic signed [AccW-1:0] acc_next_o
);

  logic signed [2*W-1:0]  prod;
  logic signed [AccW-1:0] acc_q, acc_d;

  always_comb begin
    prod       = (2*W)'($signed(a_i)) * (2*W)'($signed(b_i));
    acc_next_o = acc_q + AccW'(prod);
    acc_d      = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_next_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N signed matrix multiplier: one shared MAC, N^3 compute cycles, start/done.
module matrix_mult_seq #(
  parameter int unsigned N   = matrix_pkg::DefN,
  parameter int unsigned W   = matrix_pkg::DefW,
  parameter int unsigned SAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N*N*W-1:0] m1,
  input  logic [N*N*W-1:0] m2,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] m_out
);
  import matrix_pkg::*;

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned AccW = 2 * W + $clog2(N);
  localparam int unsigned MW   = N * N * W;
  localparam logic [IW-1:0] Last = IW'(N - 1);

  state_e            state_q, state_d;
  logic [MW-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, m_out_q, m_out_d;
  logic [IW-1:0]     r_q, r_d, c_q, c_d, k_q, k_d;
  logic              done_q, done_d;
  logic              mac_clear, mac_en;
  logic [W-1:0]      op_a, op_b, result;
  logic signed [AccW-1:0] acc_next;

  assign op_a = a_q[elem_off(32'(r_q), 32'(k_q), N, W) +: W];
  assign op_b = b_q[elem_off(32'(k_q), 32'(c_q), N, W) +: W];

  mac_unit #(
    .W    (W),
    .AccW (AccW)
  ) u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (mac_clear),
    .acc_en_i   (mac_en),
    .a_i        (op_a),
    .b_i        (op_b),
    .acc_next_o (acc_next)
  );

  assign result = (SAT != 0) ? W'(sat_clamp(64'(acc_next), W)) : acc_next[W-1:0];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    m_out_d   = m_out_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    done_d    = 1'b0;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = m1;
          b_d       = m2;
          r_d       = '0;
          c_d       = '0;
          k_d       = '0;
          mac_clear = 1'b1;
          state_d   = StCompute;
        end
      end
      StCompute: begin
        if (k_q == Last) begin
          // Final term of the dot product: store it and restart the accumulator.
          res_d[elem_off(32'(r_q), 32'(c_q), N, W) +: W] = result;
          mac_clear = 1'b1;
          k_d       = '0;
          if (c_q == Last) begin
            c_d = '0;
            if (r_q == Last) begin
              r_d     = '0;
              state_d = StDone;
            end else begin
              r_d = r_q + IW'(1);
            end
          end else begin
            c_d = c_q + IW'(1);
          end
        end else begin
          mac_en = 1'b1;
          k_d    = k_q + IW'(1);
        end
      end
      StDone: begin
        m_out_d = res_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      m_out_q <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      m_out_q <= m_out_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign m_out = m_out_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: 4x4x16 wrap and saturate instances plus a 2x2x8 instance.
module tb_matrix_mult_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start4, busy4, done4, busy4s, done4s;
  logic [255:0] m1_4, m2_4, m_out4, m_out4s;
  logic         start2, busy2, done2;
  logic [31:0]  m1_2, m2_2, m_out2;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_w = '0, last_s = '0;
  logic [31:0]  last2 = '0;

  matrix_mult_seq #(.N(4), .W(16), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start4), .m1(m1_4), .m2(m2_4),
    .busy(busy4), .done(done4), .m_out(m_out4));

  matrix_mult_seq #(.N(4), .W(16), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .start(start4), .m1(m1_4), .m2(m2_4),
    .busy(busy4s), .done(done4s), .m_out(m_out4s));

  matrix_mult_seq #(.N(2), .W(8), .SAT(0)) u_small (
    .clk(clk), .reset(reset), .start(start2), .m1(m1_2), .m2(m2_2),
    .busy(busy2), .done(done2), .m_out(m_out2));

  typedef struct {
    string        name;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp_w;
    logic [255:0] exp_s;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: textbook row-by-column sums in 64-bit integers, then wrap or clamp.
  function automatic logic [255:0] ref_mult(input logic [255:0] a, input logic [255:0] b,
                                            input int n, input int w, input bit sat);
    logic [255:0] res;
    longint mask, hi, lo, s, x, y;
    res  = '0;
    mask = (longint'(1) << w) - 1;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -hi - 1;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          x = longint'(a >> ((r * n + k) * w)) & mask;
          y = longint'(b >> ((k * n + c) * w)) & mask;
          if (x > hi) x = x - (mask + 1);
          if (y > hi) y = y - (mask + 1);
          s = s + x * y;
        end
        if (sat) s = (s > hi) ? hi : ((s < lo) ? lo : s);
        res = res | (256'(s & mask) << ((r * n + c) * w));
      end
    end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] rand_small();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'($urandom_range(0, 400)) - 16'd200;
    return v;
  endfunction

  // Launch one 4x4 operation from an IDLE cycle and follow it to the done pulse.
  task automatic do_op4(input string nm, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] exp_w, input logic [255:0] exp_s, input bit guard);
    int lat = -1;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    start4 = 1'b1;
    m1_4   = a;
    m2_4   = b;
    @(posedge clk); #1;
    start4 = 1'b0;
    m1_4   = rand256();
    m2_4   = rand256();
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start4 = guard && (cyc == 10 || cyc == 64);
      if (start4) begin
        m1_4 = rand256();
        m2_4 = rand256();
      end
      if (done4) begin
        lat = cyc;
        break;
      end
      if (busy4 !== 1'b1 || busy4s !== 1'b1) busy_ok = 1'b0;
      if (m_out4 !== last_w || m_out4s !== last_s) hold_ok = 1'b0;
    end
    start4 = 1'b0;
    chk_int({nm, " latency"}, lat, 65);
    chk({nm, " wrap result"}, m_out4, exp_w);
    chk({nm, " sat result"}, m_out4s, exp_s);
    chk_int({nm, " sat done"}, int'(done4s), 1);
    chk_int({nm, " busy low at done"}, int'(busy4), 0);
    chk_int({nm, " busy during op"}, int'(busy_ok), 1);
    chk_int({nm, " m_out held"}, int'(hold_ok), 1);
    last_w = exp_w;
    last_s = exp_s;
  endtask

  task automatic do_op2(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat = -1;
    bit hold_ok = 1'b1;
    start2 = 1'b1;
    m1_2   = a;
    m2_2   = b;
    @(posedge clk); #1;
    start2 = 1'b0;
    m1_2   = $urandom;
    m2_2   = $urandom;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = cyc;
        break;
      end
      if (m_out2 !== last2 || busy2 !== 1'b1) hold_ok = 1'b0;
    end
    chk_int({nm, " latency"}, lat, 9);
    chk({nm, " result"}, 256'(m_out2), 256'(exp));
    chk_int({nm, " busy/hold"}, int'(hold_ok), 1);
    last2 = exp;
  endtask

  initial begin
    logic [255:0] ident, seq, a, b;
    bit quiet;
    reset  = 1'b1;
    start4 = 1'b0;
    start2 = 1'b0;
    m1_4   = '0;
    m2_4   = '0;
    m1_2   = '0;
    m2_2   = '0;
    #2;
    chk("reset busy/done", 256'({busy4, done4, busy4s, done4s, busy2, done2}), '0);
    chk("reset m_out", m_out4 | m_out4s | 256'(m_out2), '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    ident = '0;
    seq   = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == c) ident[(r*4+c)*16 +: 16] = 16'd1;
        seq[(r*4+c)*16 +: 16] = 16'(r * 4 + c);
      end
    end
    tbl[0] = '{"identity", ident, seq, seq, seq};
    tbl[1] = '{"const 2x3", {16{16'h0002}}, {16{16'h0003}}, {16{16'h0018}}, {16{16'h0018}}};
    tbl[2] = '{"const 1x1", {16{16'h0001}}, {16{16'h0001}}, {16{16'h0004}}, {16{16'h0004}}};
    tbl[3] = '{"max x max", {16{16'h7FFF}}, {16{16'h7FFF}}, {16{16'h0004}}, {16{16'h7FFF}}};
    tbl[4] = '{"min x max", {16{16'h8000}}, {16{16'h7FFF}}, {16{16'h0000}}, {16{16'h8000}}};
    // Each operation starts in the IDLE cycle that carries the previous done pulse.
    for (int i = 0; i < 5; i++) do_op4(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].exp_w,
                                       tbl[i].exp_s, 1'b0);

    a = rand256();
    b = rand256();
    do_op4("busy guard", a, b, ref_mult(a, b, 4, 16, 1'b0), ref_mult(a, b, 4, 16, 1'b1), 1'b1);
    @(posedge clk); #1;
    chk_int("guard no restart", int'(busy4 | done4), 0);

    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? rand256() : rand_small();
      b = (i % 2 == 0) ? rand256() : rand_small();
      do_op4("random", a, b, ref_mult(a, b, 4, 16, 1'b0), ref_mult(a, b, 4, 16, 1'b1), 1'b0);
    end

    start4 = 1'b1;
    m1_4   = rand256();
    m2_4   = rand256();
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid-op reset outputs", 256'({busy4, done4, busy4s, done4s}), '0);
    chk("mid-op reset m_out", m_out4 | m_out4s, '0);
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done4 || done4s || busy4) quiet = 1'b0;
    end
    chk_int("reset held quiet", int'(quiet), 1);
    @(negedge clk);
    reset  = 1'b0;
    last_w = '0;
    last_s = '0;
    last2  = '0;
    @(posedge clk); #1;
    a = rand_small();
    b = rand_small();
    do_op4("after reset", a, b, ref_mult(a, b, 4, 16, 1'b0), ref_mult(a, b, 4, 16, 1'b1), 1'b0);

    do_op2("n2 directed", 32'h0403_0201, 32'h0807_0605, 32'h322B_1613);
    for (int i = 0; i < 4; i++) begin
      a = 256'($urandom);
      b = 256'($urandom);
      seq = ref_mult(a, b, 2, 8, 1'b0);
      do_op2("n2 random", a[31:0], b[31:0], seq[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
